// File: rtl/avalon_pkg.sv
// Shared types for the Avalon-MM register slave: response codes, FSM states
// and the read-pipeline beat record.
package avalon_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY        = 2'b00,
    RESP_RESERVED    = 2'b01,
    RESP_SLVERR      = 2'b10,
    RESP_DECODEERROR = 2'b11
  } avs_resp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } avs_state_e;

  typedef struct packed {
    logic      valid;
    logic [31:0] data;
    avs_resp_e resp;
  } rd_beat_t;

  localparam rd_beat_t RD_BEAT_IDLE = '{valid: 1'b0, data: 32'h0, resp: RESP_OKAY};

endpackage

// File: rtl/avs_read_pipe.sv
// Fixed-latency read return pipeline: READ_LATENCY register stages of
// {valid, data, resp}; the last stage drives the slave outputs directly.
module avs_read_pipe
  import avalon_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  input  rd_beat_t beat_in,
  output rd_beat_t beat_out
);

  rd_beat_t stage_r [READ_LATENCY];

  // Shift one beat per cycle; reset drops every in-flight read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_r[i] <= RD_BEAT_IDLE;
      end
    end else begin
      stage_r[0] <= beat_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign beat_out = stage_r[READ_LATENCY-1];

endmodule

// File: rtl/avalon_reg_slave.sv
// Avalon-MM register bank slave with fixed wait states and fixed read latency.
// Define AVS_ERR_RESP_EN to range-check addresses and answer DECODEERROR.
module avalon_reg_slave
  import avalon_pkg::*;
#(
  parameter int          WAIT_STATES  = 2,
  parameter int          READ_LATENCY = 2,
  parameter int          DEPTH        = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic        readdatavalid,
  output logic [31:0] readdata,
  output logic [1:0]  response
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  avs_state_e       state_r, state_nxt_s;
  logic [3:0]       cnt_r, cnt_nxt_s;
  logic             cmd_s, accept_s, wait_s;
  logic             wr_en_s, rd_en_s, in_range_s;
  logic [31:0]      offset_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      mem_r [DEPTH];
  rd_beat_t         beat_in_s, beat_out_s;

  assign cmd_s    = read | write;
  assign offset_s = address - BASE_ADDR;
  assign idx_s    = offset_s[IDX_W+1:2];

`ifdef AVS_ERR_RESP_EN
  // Subtraction wraps below BASE_ADDR, so both bounds are checked explicitly.
  assign in_range_s = (address >= BASE_ADDR) && (offset_s < 32'(DEPTH * 4));
`else
  logic unused_offset_s;
  assign unused_offset_s = ^{offset_s[31:IDX_W+2], offset_s[1:0]};
  assign in_range_s      = 1'b1;
`endif

  // Wait-state sequencer: next state, counter and accept strobe.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    wait_s      = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!cmd_s) begin
          cnt_nxt_s = 4'd0;
        end else if (WS == 4'd0) begin
          accept_s = 1'b1;
        end else begin
          wait_s      = 1'b1;
          cnt_nxt_s   = 4'd1;
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!cmd_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r < WS) begin
          wait_s    = 1'b1;
          cnt_nxt_s = cnt_r + 4'd1;
        end else begin
          accept_s    = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Write wins when read and write arrive together; that read is dropped.
  assign wr_en_s = accept_s & write & in_range_s;
  assign rd_en_s = accept_s & read & ~write;

  // Register bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0;
      end
    end else if (wr_en_s) begin
      mem_r[idx_s] <= writedata;
    end
  end

  // Snapshot the addressed word at accept so later writes cannot disturb it.
  always_comb begin
    beat_in_s = RD_BEAT_IDLE;
    if (rd_en_s) begin
      beat_in_s.valid = 1'b1;
      if (in_range_s) begin
        beat_in_s.data = mem_r[idx_s];
        beat_in_s.resp = RESP_OKAY;
      end else begin
        beat_in_s.data = 32'h0;
        beat_in_s.resp = RESP_DECODEERROR;
      end
    end else begin
      beat_in_s = RD_BEAT_IDLE;
    end
  end

  avs_read_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .beat_in (beat_in_s),
    .beat_out(beat_out_s)
  );

  assign waitrequest   = wait_s;
  assign readdatavalid = beat_out_s.valid;
  assign readdata      = beat_out_s.data;
  assign response      = beat_out_s.resp;

endmodule

// File: tb/tb_avalon_reg_slave.sv
// Randomized self-checking bench: instance 0 uses defaults, instance 1 uses
// WAIT_STATES=0/READ_LATENCY=1; both are checked against a word-array model.
`timescale 1ns/1ps
module tb_avalon_reg_slave;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef AVS_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0][31:0] address, writedata, readdata;
  logic [1:0]       read, write, waitrequest, readdatavalid;
  logic [1:0][1:0]  response;

  logic [31:0] mem_m [2][DEPTH];
  exp_t        q0[$], q1[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  avalon_reg_slave u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address[0]), .write(write[0]),
    .read(read[0]), .writedata(writedata[0]), .waitrequest(waitrequest[0]),
    .readdatavalid(readdatavalid[0]), .readdata(readdata[0]), .response(response[0])
  );

  avalon_reg_slave #(.WAIT_STATES(0), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address[1]), .write(write[1]),
    .read(read[1]), .writedata(writedata[1]), .waitrequest(waitrequest[1]),
    .readdatavalid(readdatavalid[1]), .readdata(readdata[1]), .response(response[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic int rl_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    longint off;
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    return !ERR_EN || (off >= 0 && off < DEPTH * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % DEPTH);
  endfunction

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int u);
    if (u == 0) return q0.pop_front();
    else return q1.pop_front();
  endfunction

  function automatic int qdue(input int u);
    return (u == 0) ? q0[0].due : q1[0].due;
  endfunction

  // Per-cycle output check: a pulse exactly when a read falls due, else zeros.
  task automatic mon(input int u);
    exp_t e;
    if (qsize(u) > 0 && qdue(u) == cyc) begin
      e = qpop(u);
      chk($sformatf("u%0d_rdv", u), readdatavalid[u], 1);
      chk($sformatf("u%0d_rdata", u), readdata[u], e.data);
      chk($sformatf("u%0d_resp", u), response[u], e.resp);
    end else begin
      chk($sformatf("u%0d_rdv_idle", u), readdatavalid[u], 0);
      chk($sformatf("u%0d_rdata_idle", u), readdata[u], 0);
      chk($sformatf("u%0d_resp_idle", u), response[u], 0);
    end
  endtask

  always @(negedge clk) begin
    #2;
    mon(0);
    mon(1);
  end

  // Present a command and hold it until accepted; inputs stay asserted.
  task automatic do_cmd(input int u, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
    int   waits;
    exp_t e;
    @(negedge clk);
    read[u] = rd; write[u] = wr; address[u] = a; writedata[u] = d;
    #1;
    waits = 0;
    while (waitrequest[u] && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    chk($sformatf("u%0d_wait_cycles", u), waits, ws_of(u));
    if (waits < 40) begin
      if (wr) begin
        if (in_rng(a)) mem_m[u][widx(a)] = d;
      end else if (rd) begin
        e.due  = cyc + rl_of(u);
        e.data = in_rng(a) ? mem_m[u][widx(a)] : 32'h0;
        e.resp = in_rng(a) ? 2'b00 : 2'b11;
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  task automatic go_idle(input int u, input int n);
    @(negedge clk);
    read[u] = 1'b0; write[u] = 1'b0;
    #1 chk($sformatf("u%0d_idle_wreq", u), waitrequest[u], 0);
    repeat (n - 1) @(negedge clk);
  endtask

  // Command withdrawn mid-wait must leave no trace.
  task automatic abort_cmd();
    @(negedge clk);
    read[0] = 1'b1; write[0] = 1'b0; address[0] = 32'h4;
    #1 chk("abort_wreq_hi", waitrequest[0], 1);
    @(negedge clk);
    read[0] = 1'b0;
    #1 chk("abort_wreq_lo", waitrequest[0], 0);
    @(negedge clk);
    #1 chk("abort_idle", waitrequest[0], 0);
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < DEPTH; i++) mem_m[u][i] = 32'h0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int op, w, gap;
    logic [31:0] a, d;
    reset_n = 1'b0;
    read = '0; write = '0; address = '0; writedata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) chk($sformatf("u%0d_rst_wreq", u), waitrequest[u], 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // a) write then read back with wait states and latency
    do_cmd(0, 0, 1, 32'h8, 32'hDEADBEEF);
    do_cmd(0, 1, 0, 32'h8, 32'h0);
    go_idle(0, 5);

    // b) zero-wait back-to-back reads on instance 1
    do_cmd(1, 0, 1, 32'h0, 32'h11);
    do_cmd(1, 0, 1, 32'h4, 32'h22);
    do_cmd(1, 0, 1, 32'h8, 32'h33);
    do_cmd(1, 1, 0, 32'h0, 32'h0);
    do_cmd(1, 1, 0, 32'h4, 32'h0);
    do_cmd(1, 1, 0, 32'h8, 32'h0);
    go_idle(1, 4);

    // c) write right after read must not change the returned data
    for (int u = 0; u < 2; u++) begin
      do_cmd(u, 0, 1, 32'h4, 32'h1);
      do_cmd(u, 1, 0, 32'h4, 32'h0);
      do_cmd(u, 0, 1, 32'h4, 32'h2);
      do_cmd(u, 1, 0, 32'h4, 32'h0);
      go_idle(u, 5);
    end

    // d) address just past the bank
    do_cmd(0, 0, 1, 32'h0, 32'h9);
    do_cmd(0, 1, 0, 32'h40, 32'h0);
    do_cmd(0, 0, 1, 32'h40, 32'h5);
    do_cmd(0, 1, 0, 32'h0, 32'h0);
    go_idle(0, 5);

    // f) simultaneous read and write: write wins, no read return
    do_cmd(0, 1, 1, 32'hC, 32'h7);
    go_idle(0, 4);
    do_cmd(0, 1, 0, 32'hC, 32'h0);
    go_idle(0, 4);

    abort_cmd();
    do_cmd(0, 1, 0, 32'h8, 32'h0);
    go_idle(0, 4);

    // e) reset while a read is in flight
    do_cmd(0, 0, 1, 32'h0, 32'h1234);
    do_cmd(0, 1, 0, 32'h0, 32'h0);
    @(negedge clk);
    read[0] = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_wreq", waitrequest[0], 0);
    chk("rst_rdv", readdatavalid[0], 0);
    chk("rst_rdata", readdata[0], 0);
    chk("rst_resp", response[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    do_cmd(0, 1, 0, 32'h0, 32'h0);
    do_cmd(0, 1, 0, 32'hC, 32'h0);
    go_idle(0, 5);

    // randomized traffic, one instance at a time
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 150; i++) begin
        op = $urandom_range(0, 6);
        w  = $urandom_range(0, 23);
        a  = (32'(w) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) a = $urandom | 32'hF000_0000;
        d  = $urandom;
        case (op)
          0, 1: do_cmd(u, 1, 0, a, d);
          2, 3: do_cmd(u, 0, 1, a, d);
          4:    do_cmd(u, 1, 1, a, d);
          5: begin
            gap = $urandom_range(1, 3);
            go_idle(u, gap);
          end
          default: begin
            if (u == 0) begin
              go_idle(0, 1);
              abort_cmd();
            end else begin
              do_cmd(u, 1, 0, a, d);
            end
          end
        endcase
      end
      go_idle(u, 6);
    end

    chk("pending_reads", 32'(q0.size() + q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_reg_slave.md
AVALON_REG_SLAVE -- requirements
Module: avalon_reg_slave

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
 WAIT_STATES 2: stall cycles per command (0..15).
 READ_LATENCY 2: cycles from read acceptance to readdatavalid (1..8).
 DEPTH 16: 32-bit words in bank (power of 2, 4..256).
 BASE_ADDR 32'h0: byte base address, DEPTH*4 aligned.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  sole clock, rising edge.
 reset_n  in  1  reset, asynchronous, active-low.
 address  in  32  byte address from upstream Avalon master.
 write  in  1  write command.
 read  in  1  read command.
 writedata  in  32  write data, valid with write.
 waitrequest  out  1  command not yet accepted.
 readdatavalid  out  1  readdata/response valid, one cycle per accepted read.
 readdata  out  32  read data.
 response  out  2  00 OKAY, 10 SLVERR, 11 DECODEERROR.

Function
REQ-003 SHALL accept a command in the cycle where (read|write) & !waitrequest; acceptance = "accept" below.
REQ-004 SHALL drive waitrequest low whenever no command is presented (idle), so an upstream master may update address while idle.
REQ-005 SHALL use FSM IDLE/WAIT with 4-bit wait counter: IDLE + command + WAIT_STATES==0 -> accept, stay IDLE; IDLE + command + WAIT_STATES>0 -> waitrequest=1, counter=1, go WAIT.
REQ-006 In WAIT SHALL drive waitrequest=1 while counter<WAIT_STATES (counter increments), and waitrequest=0 with accept and return to IDLE when counter==WAIT_STATES; a command is thus held WAIT_STATES+1 cycles.
REQ-007 If read and write both drop in WAIT, SHALL return to IDLE next cycle with no side effect and waitrequest=0.
REQ-008 With read and write both high, write SHALL win; the read is discarded (no readdatavalid).
REQ-009 Word index = (address-BASE_ADDR)>>2; address[1:0] ignored; in-range iff BASE_ADDR <= address < BASE_ADDR+DEPTH*4.
REQ-010 Accepted in-range write SHALL update the word at the accept edge; write-only: no readdatavalid, no response pulse.
REQ-011 Accepted read SHALL sample word data at the accept edge and assert readdatavalid exactly READ_LATENCY cycles later for one cycle with that data and response.
REQ-012 Back-to-back accepted reads SHALL yield back-to-back readdatavalid pulses in order; a write accepted after a read SHALL NOT alter that read's data.
REQ-013 readdata SHALL be 32'h0 and response 2'b00 whenever readdatavalid=0.

Reset
REQ-014 On reset_n low, asynchronously: state IDLE, counter 0, all words 0, read pipeline emptied, waitrequest=0, readdatavalid=0, readdata=0, response=00.
REQ-015 Reads pending at reset SHALL be discarded; no readdatavalid after reset_n rises for them.
REQ-016 First command SHALL be accepted no earlier than the first rising edge after reset_n deasserts.

Configuration
REQ-017 Macro AVS_ERR_RESP_EN: when defined, out-of-range accepted writes are dropped and out-of-range reads return readdata=0, response=2'b11 (DECODEERROR); wait/latency timing unchanged.
REQ-018 Without AVS_ERR_RESP_EN: no range check; index wraps modulo DEPTH; response always 2'b00.

Structure
REQ-019 Package avalon_pkg SHALL hold the response enum (OKAY 00, RESERVED 01, SLVERR 10, DECODEERROR 11) and the FSM state typedef.
REQ-020 Read pipeline SHALL be sub-module avs_read_pipe: READ_LATENCY-stage shift of {valid, data[31:0], resp[1:0]}, asynchronous reset clears valid bits.

Verification
REQ-021 Bench SHALL cover, with defaults unless stated:
 a) Write 32'hDEADBEEF @0x8, read 0x8 -> waitrequest high 2 cycles each; readdatavalid 2 cycles after read accept, readdata DEADBEEF, response 00.
 b) WAIT_STATES=0, READ_LATENCY=1, reads 0x0,0x4,0x8 back-to-back -> waitrequest never high; 3 consecutive readdatavalid pulses in order.
 c) Read 0x4 (holds 1), write 0x4=2 on the next accept -> readdatavalid data 1, later read returns 2.
 d) AVS_ERR_RESP_EN, read 0x40 (DEPTH 16) -> readdata 0, response 11; write 0x40=5 then read 0x0 -> 0. Without macro: read 0x40 returns word 0.
 e) read asserted, reset_n pulsed low 1 cycle after accept -> no readdatavalid; all outputs 0; subsequent read 0x0 returns 0.
 f) read and write both high, addr 0xC, data 7 -> word 3 = 7, no readdatavalid.
